// File: rtl/bus_mem_responder.sv
// Word-wide big-endian memory responder with programmable wait states and a ready/err handshake.
// Define BUS_MEM_PRELOAD_EN to have reset load the sum-loop program image instead of clearing memory.
module bus_mem_responder #(
   parameter int MEM_BYTES   = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic        rw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);
   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic          rw_reg;
   logic [31:0]   addr_reg, wdata_reg, rdata_reg;
   logic          ready_reg, err_reg;
   logic          do_access, range_err;
   logic [AW-1:0] base;
   logic [31:0]   read_word;

   logic [7:0]           mem [MEM_BYTES];
   logic [MEM_BYTES-1:0] byte_we;
   logic [7:0]           byte_wval [MEM_BYTES];
   logic [7:0]           byte_init [MEM_BYTES];

`ifdef BUS_MEM_PRELOAD_EN
   function automatic logic [7:0] init_byte(input int i);
      logic [31:0] w;
      case (i / 4)
         0:       w = 32'h001F0018;
         1:       w = 32'h002F0010;
         2:       w = 32'h003F0014;
         3:       w = 32'h13221000;
         4:       w = 32'h13332000;
         5:       w = 32'h26FFFFF4;
         7:       w = 32'h00000001;
         default: w = 32'h00000000;
      endcase
      return w[8 * (3 - (i % 4)) +: 8];
   endfunction
`endif

   // In-range guarantees base+3 < MEM_BYTES, so the modular offset never wraps into 0..3 falsely.
   assign range_err = addr_reg > 32'(MEM_BYTES - 4);
   assign base      = addr_reg[AW-1:0];
   assign read_word = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};

   genvar gi;
   generate
      for (gi = 0; gi < MEM_BYTES; gi++) begin : g_byte
         logic [AW-1:0] offset;
         logic [1:0]    lane;
         assign offset         = AW'(gi) - base;
         assign lane           = 2'd3 - offset[1:0];
         assign byte_we[gi]    = do_access && !rw_reg && !range_err && (offset < AW'(4));
         assign byte_wval[gi]  = wdata_reg[{lane, 3'b000} +: 8];
`ifdef BUS_MEM_PRELOAD_EN
         assign byte_init[gi]  = init_byte(gi);
`else
         assign byte_init[gi]  = 8'h00;
`endif
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      do_access  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (en) begin
               state_next = WAIT;
               cnt_next   = 4'(WAIT_CYCLES);
            end
         end
         WAIT: begin
            if (!en) begin
               state_next = IDLE;
            end else if (cnt_reg == 4'd0) begin
               do_access  = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = en ? HOLD : IDLE;
         HOLD:    if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         rw_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= byte_init[i];
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && en) begin
            rw_reg    <= rw;
            addr_reg  <= addr;
            wdata_reg <= wdata;
         end
         ready_reg <= do_access;
         err_reg   <= do_access && range_err;
         if (do_access && range_err)   rdata_reg <= 32'd0;
         else if (do_access && rw_reg) rdata_reg <= read_word;
         for (int i = 0; i < MEM_BYTES; i++)
            if (byte_we[i]) mem[i] <= byte_wval[i];
      end
   end

   assign rdata = rdata_reg;
   assign ready = ready_reg;
   assign err   = err_reg;
   assign busy  = (state_reg != IDLE);
endmodule
